// File: rtl/switch_debounce_ctrl.sv
// switch_debounce_ctrl: synchronizes and debounces 64 active-low switch lines,
// commits clean values to a stable register and raises a maskable change
// interrupt with write-1-to-clear acknowledge. Word-addressed bus slave.
module switch_debounce_ctrl #(
  parameter int unsigned DEBOUNCE = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [63:0] raw_sw,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  localparam logic [2:0]  A_CTRL   = 3'b000;
  localparam logic [2:0]  A_STATUS = 3'b001;
  localparam logic [2:0]  A_STATE  = 3'b010;
  localparam logic [2:0]  A_SW_LO  = 3'b011;
  localparam logic [2:0]  A_SW_HI  = 3'b100;
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE - 1);

  logic [63:0] sync1_q, sync2_q;
  logic [63:0] stable_q, cand_q;
  logic [19:0] cnt_q;
  state_e      state_q;
  logic        ie_q, pend_q, chg_lo_q, chg_hi_q;
  logic        w1c;
  logic        unused_wdata;

  assign w1c          = we && (addr == A_STATUS) && wdata[0];
  assign unused_wdata = ^wdata[31:1];

  // Two-flop synchronizer; inverts so logic-1 means switch on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~raw_sw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM plus status bits; a commit is written after the W1C so it
  // wins when both land on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      chg_lo_q <= 1'b0;
      chg_hi_q <= 1'b0;
    end else begin
      if (w1c) begin
        pend_q   <= 1'b0;
        chg_lo_q <= 1'b0;
        chg_hi_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sync2_q != stable_q) begin
            cand_q  <= sync2_q;
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (sync2_q == stable_q) begin
            state_q <= IDLE;
          end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            stable_q <= cand_q;
            chg_lo_q <= (cand_q[31:0]  != stable_q[31:0]);
            chg_hi_q <= (cand_q[63:32] != stable_q[63:32]);
            pend_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
      endcase
    end
  end

  // Interrupt enable register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ie_q <= 1'b0;
    else if (we && (addr == A_CTRL)) ie_q <= wdata[0];
  end

  // Combinational read mux; reads have no side effects.
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL:   rdata = {31'b0, ie_q};
      A_STATUS: rdata = {29'b0, chg_hi_q, chg_lo_q, pend_q};
      A_STATE:  rdata = {31'b0, state_q == COUNT};
      A_SW_LO:  rdata = stable_q[31:0];
      A_SW_HI:  rdata = stable_q[63:32];
      default:  rdata = '0;
    endcase
  end

  assign irq = pend_q & ie_q;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl with DEBOUNCE = 4.
module tb_switch_debounce_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [63:0] raw_sw;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [2:0]  a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[18];

  switch_debounce_ctrl #(.DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
    .raw_sw(raw_sw), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chkr(input string nm, input logic [2:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic chki(input string nm, input logic exp);
    #1;
    chk(nm, {31'b0, irq}, {31'b0, exp});
  endtask

  // Drive a single-cycle write; returns in the low phase after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    addr   = '0;
    we     = 1'b0;
    wdata  = '0;
    raw_sw = '1;

    // Register-level vectors applied right after reset release.
    for (int i = 0; i < 8; i++) vecs[i] = '{3'(i), 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[8]  = '{3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[9]  = '{3'd0, 1'b0, 32'h0,         32'h1, 1'b0};
    vecs[10] = '{3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[11] = '{3'd5, 1'b0, 32'h0,         32'h0, 1'b0};
    vecs[12] = '{3'd2, 1'b1, 32'h1,         32'h0, 1'b0};
    vecs[13] = '{3'd2, 1'b0, 32'h0,         32'h0, 1'b0};
    vecs[14] = '{3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[15] = '{3'd3, 1'b0, 32'h0,         32'h0, 1'b0};
    vecs[16] = '{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[17] = '{3'd4, 1'b0, 32'h0,         32'h0, 1'b0};

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    chki("rst_irq", 1'b0);
    for (int a = 0; a < 8; a++) chkr($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      addr  = vecs[i].a;
      we    = vecs[i].w;
      wdata = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_rd", i), rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      @(negedge clk);
      we    = 1'b0;
      wdata = '0;
    end

    // No activity with all switches off.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chkr($sformatf("idle_state%0d", c), 3'd2, 32'h0);
    end

    // Clean change on switch 0, commit at t+6, interrupt, W1C.
    @(negedge clk);
    raw_sw[0] = 1'b0;
    repeat (6) @(negedge clk);
    chkr("sw0_t5_lo", 3'd3, 32'h0);
    chkr("sw0_t5_state", 3'd2, 32'h1);
    @(negedge clk);
    chkr("sw0_t6_lo", 3'd3, 32'h1);
    chkr("sw0_status", 3'd1, 32'h3);
    chki("sw0_irq", 1'b1);
    chkr("sw0_state_idle", 3'd2, 32'h0);
    wr(3'd1, 32'h1);
    chkr("sw0_clr_status", 3'd1, 32'h0);
    chki("sw0_clr_irq", 1'b0);

    // Bounce on switch 40: low 2, high 1, then low held.
    @(negedge clk);
    raw_sw[40] = 1'b0;
    repeat (2) @(negedge clk);
    raw_sw[40] = 1'b1;
    @(negedge clk);
    raw_sw[40] = 1'b0;
    repeat (2) @(negedge clk);
    chkr("bnc_abandon_state", 3'd2, 32'h0);
    repeat (4) @(negedge clk);
    chkr("bnc_t5_hi", 3'd4, 32'h0);
    chkr("bnc_t5_status", 3'd1, 32'h0);
    @(negedge clk);
    chkr("bnc_t6_hi", 3'd4, 32'h100);
    chkr("bnc_status", 3'd1, 32'h5);
    chki("bnc_irq", 1'b1);
    wr(3'd1, 32'h1);
    chkr("bnc_clr", 3'd1, 32'h0);

    // Pulse shorter than debounce on switch 5.
    @(negedge clk);
    raw_sw[5] = 1'b0;
    repeat (3) @(negedge clk);
    raw_sw[5] = 1'b1;
    @(negedge clk);
    chkr("pls_count_a", 3'd2, 32'h1);
    @(negedge clk);
    chkr("pls_count_b", 3'd2, 32'h1);
    @(negedge clk);
    chkr("pls_idle", 3'd2, 32'h0);
    repeat (5) @(negedge clk);
    chkr("pls_lo", 3'd3, 32'h1);
    chkr("pls_status", 3'd1, 32'h0);
    chki("pls_irq", 1'b0);

    // Masked interrupt, late enable, commit coinciding with W1C.
    wr(3'd0, 32'h0);
    raw_sw[1] = 1'b0;
    repeat (7) @(negedge clk);
    chkr("msk_lo", 3'd3, 32'h3);
    chkr("msk_status", 3'd1, 32'h3);
    chki("msk_irq", 1'b0);
    wr(3'd0, 32'h1);
    chki("msk_en_irq", 1'b1);
    raw_sw[33] = 1'b0;
    repeat (6) @(negedge clk);
    chkr("race_pre_hi", 3'd4, 32'h100);
    wr(3'd1, 32'h1);
    chkr("race_status", 3'd1, 32'h5);
    chkr("race_hi", 3'd4, 32'h102);
    chki("race_irq", 1'b1);
    wr(3'd1, 32'h1);
    chkr("race_clr", 3'd1, 32'h0);
    chki("race_clr_irq", 1'b0);

    // Reset mid-COUNT (cnt = 2), then recommit from a clean slate.
    @(negedge clk);
    raw_sw[2] = 1'b0;
    repeat (5) @(negedge clk);
    chkr("mid_state", 3'd2, 32'h1);
    reset = 1'b0;
    chki("mid_rst_irq", 1'b0);
    for (int a = 0; a < 8; a++) chkr($sformatf("mid_rst_rd%0d", a), 3'(a), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chkr("rel_t5_lo", 3'd3, 32'h0);
    chkr("rel_t5_state", 3'd2, 32'h1);
    @(negedge clk);
    chkr("rel_t6_lo", 3'd3, 32'h7);
    chkr("rel_t6_hi", 3'd4, 32'h102);
    chkr("rel_status", 3'd1, 32'h7);
    chki("rel_irq", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debounce_ctrl.md
# switch_debounce_ctrl

Controller for the board DIP-switch input path. It synchronizes and debounces all 64 switch lines (8 banks × 8, active-low at the pins) and commits each clean value to a stable register. It raises a maskable change interrupt to the CPU with a write-1-to-clear acknowledge. It sits on the peripheral bus as a word-addressed read/write device and replaces the free-running sample registers of the switch path.

## Interface
- DEBOUNCE, default 1000: number of consecutive matching cycles required before a new switch value is committed; legal range 1..2^20-1.
- clk  input  1: system clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-low reset.
- addr  input  3: word address bits [4:2] of the bus access.
- we  input  1: bus write strobe, single cycle.
- wdata  input  32: bus write data.
- raw_sw  input  64: switch pins; bank k at bits [8k+7:8k]; active-low.
- rdata  output  32: combinational read data for addr.
- irq  output  1: interrupt request, level, high while pending and enabled.

## Operation
- Input conditioning:
  - Two-flop synchronizer on ~raw_sw, giving sync (logic-1 = switch on).
  - The synchronizer flops reset to 0.
- Debounce FSM, states IDLE and COUNT:
  - IDLE, sync == stable: stay.
  - IDLE, sync != stable: cand <= sync, cnt <= 0, go to COUNT.
  - COUNT, sync == stable: abandon the change, go to IDLE; stable is unchanged and pending is not touched.
  - COUNT, sync != cand and sync != stable: cand <= sync, cnt <= 0, stay in COUNT.
  - COUNT, sync == cand, cnt == DEBOUNCE-1: commit. stable <= cand, chg_lo <= (cand[31:0] != stable[31:0]), chg_hi <= (cand[63:32] != stable[63:32]), pending <= 1, go to IDLE.
  - COUNT, sync == cand, cnt < DEBOUNCE-1: cnt <= cnt+1.
  - cnt is 20 bits and never wraps, because the commit occurs at DEBOUNCE-1.
- Register map (addr), all reads combinational:
  - 000 CTRL: bit0 ie, read/write; other bits read 0, writes ignored.
  - 001 STATUS: bit0 pending, bit1 chg_lo, bit2 chg_hi; writing 1 to bit0 clears pending, chg_lo and chg_hi.
  - 010 STATE: bit0 = 1 when the FSM is in COUNT; read-only.
  - 011 SW_LO: stable[31:0].
  - 100 SW_HI: stable[63:32].
  - 101..111: read 0; writes ignored.
- irq = pending & ie.
  - pending sets regardless of ie.
  - Enabling ie while pending asserts irq on the next cycle.
- Simultaneous commit and STATUS W1C on the same edge: the commit wins. pending stays 1, and chg_* take the new commit's values; they do not accumulate.
- Reset (any time, including mid-COUNT):
  - All flops to 0: sync stages, stable, cand, cnt, ie, pending, chg_lo, chg_hi; FSM to IDLE.
  - Output values during reset: irq = 0; rdata = 0 for every address.
  - Switches that are on at reset release commit after debounce and set pending.

## Timing
- The raw change is sampled at edge t. Provided it holds, stable updates and pending sets at edge t+DEBOUNCE+2:
  - sync valid after edge t+1.
  - FSM enters COUNT at edge t+2.
  - Commit after DEBOUNCE further edges.
- Any glitch that returns to the old value before commit produces no commit and no pending.
- A glitch to a third value restarts the count from that glitch.
- irq rises in the same cycle pending is visible, i.e. after the commit edge when ie = 1.
- Writes take effect at the edge where we = 1. STATUS clear drops irq after that edge.
- rdata has zero-cycle latency from addr; reads have no side effects.

## Test plan
- Reset, then raw_sw = all 1s held, DEBOUNCE = 4:
  - rdata = 0 at every address.
  - irq = 0.
  - STATE reads 0 for 100 cycles.
- Write CTRL = 1. Drive raw_sw[0] = 0 at edge t and hold:
  - SW_LO = 0x00000001 at edge t+6.
  - STATUS = 0x3; irq = 1.
  - Write STATUS = 1: STATUS = 0, irq = 0 next cycle.
- Bounce: raw_sw[40] low for 2 cycles, high 1 cycle, then low held:
  - No commit during the bounce.
  - SW_HI = 0x00000100 exactly 6 edges after the final low edge.
  - STATUS bit2 = 1, bit1 = 0.
- Pulse shorter than debounce: raw_sw[5] low for 3 cycles, then high:
  - FSM returns to IDLE; SW_LO unchanged.
  - pending stays 0.
- ie = 0, trigger a change:
  - pending = 1, irq = 0.
  - Write CTRL = 1: irq = 1 after that edge.
  - Drive a commit on the same edge as a STATUS W1C write: pending remains 1.
- Assert reset mid-COUNT (cnt = 2):
  - All registers 0 and irq = 0 immediately, independent of clk.
  - After release with switches held, the commit occurs DEBOUNCE+2 edges later.
